// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Synchronizes, debounces and queues four direction buttons,
//               then releases one move command per mv_tick by fixed priority.
//               Define BUTTON_CONDITIONER_AUTOREPEAT_EN to add held-key repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
  parameter int DEB_CYCLES    = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 7000000
) (
  input  logic       CLK,
  input  logic       clear,
  input  logic       Left,
  input  logic       Right,
  input  logic       Up,
  input  logic       Down,
  input  logic       mv_tick,
  output logic       mv_right,
  output logic       mv_left,
  output logic       mv_up,
  output logic       mv_down,
  output logic [3:0] held
);

  localparam int c_max_ab  = (DEB_CYCLES > REPEAT_DELAY) ? DEB_CYCLES : REPEAT_DELAY;
  localparam int c_max_cnt = (c_max_ab > REPEAT_PERIOD) ? c_max_ab : REPEAT_PERIOD;
  localparam int c_cnt_w   = $clog2(c_max_cnt + 1);
  localparam logic [c_cnt_w-1:0] c_deb_last = c_cnt_w'(DEB_CYCLES - 1);

  // Bit order everywhere is {Down, Up, Left, Right}; index 0 has top priority.
  logic [3:0] w_raw;
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_event;
  logic [3:0] r_pending;
  logic [3:0] w_grant;

  assign w_raw = {Down, Up, Left, Right};

  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      logic [c_cnt_w-1:0] r_deb_cnt;
      logic               r_stable;
      logic               w_deb_done;
      logic               w_press;

      assign w_deb_done = (r_sync2[gi] != r_stable) && (r_deb_cnt == c_deb_last);
      assign w_press    = w_deb_done & ~r_stable;
      assign held[gi]   = r_stable;

      always_ff @(posedge CLK or posedge clear) begin
        if (clear) begin
          r_deb_cnt <= '0;
          r_stable  <= 1'b0;
        end else if (r_sync2[gi] == r_stable) begin
          r_deb_cnt <= '0;
        end else if (w_deb_done) begin
          r_deb_cnt <= '0;
          r_stable  <= ~r_stable;
        end else begin
          r_deb_cnt <= r_deb_cnt + 1'b1;
        end
      end

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
      localparam logic [c_cnt_w-1:0] c_dly_last = c_cnt_w'(REPEAT_DELAY - 1);
      localparam logic [c_cnt_w-1:0] c_per_last = c_cnt_w'(REPEAT_PERIOD - 1);
      logic [c_cnt_w-1:0] r_rep_cnt;
      logic               r_rep_phase;
      logic               w_rep_hit;

      // A release on this edge (w_deb_done while stable) suppresses any repeat.
      assign w_rep_hit = r_stable && !w_deb_done &&
                         (r_rep_cnt == (r_rep_phase ? c_per_last : c_dly_last));

      always_ff @(posedge CLK or posedge clear) begin
        if (clear) begin
          r_rep_cnt   <= '0;
          r_rep_phase <= 1'b0;
        end else if (!r_stable || w_deb_done) begin
          r_rep_cnt   <= '0;
          r_rep_phase <= 1'b0;
        end else if (w_rep_hit) begin
          r_rep_cnt   <= '0;
          r_rep_phase <= 1'b1;
        end else begin
          r_rep_cnt <= r_rep_cnt + 1'b1;
        end
      end

      assign w_event[gi] = w_press | w_rep_hit;
`else
      assign w_event[gi] = w_press;
`endif
    end
  endgenerate

  always_comb begin
    w_grant = 4'b0000;
    if (mv_tick) begin
      if (r_pending[0])      w_grant = 4'b0001;
      else if (r_pending[1]) w_grant = 4'b0010;
      else if (r_pending[2]) w_grant = 4'b0100;
      else if (r_pending[3]) w_grant = 4'b1000;
    end
  end

  // A new event on the consuming edge re-arms the bit, so set beats clear.
  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      r_pending <= 4'b0000;
      mv_right  <= 1'b0;
      mv_left   <= 1'b0;
      mv_up     <= 1'b0;
      mv_down   <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_grant) | w_event;
      mv_right  <= w_grant[0];
      mv_left   <= w_grant[1];
      mv_up     <= w_grant[2];
      mv_down   <= w_grant[3];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Directed self-checking bench for button_conditioner with a
//               window-based behavioural model compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

  localparam int DEB = 4;
  localparam int RDLY = 20;
  localparam int RPER = 8;

  logic CLK = 1'b0;
  logic clear;
  logic Left, Right, Up, Down, mv_tick;
  logic mv_right, mv_left, mv_up, mv_down;
  logic [3:0] held;
  logic [3:0] mv;

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;

  assign mv = {mv_down, mv_up, mv_left, mv_right};

  button_conditioner #(
    .DEB_CYCLES   (DEB),
    .REPEAT_DELAY (RDLY),
    .REPEAT_PERIOD(RPER)
  ) dut (
    .CLK     (CLK),
    .clear   (clear),
    .Left    (Left),
    .Right   (Right),
    .Up      (Up),
    .Down    (Down),
    .mv_tick (mv_tick),
    .mv_right(mv_right),
    .mv_left (mv_left),
    .mv_up   (mv_up),
    .mv_down (mv_down),
    .held    (held)
  );

  always #5 CLK = ~CLK;

  // Model: hist[k] is the raw sample taken k+1 edges ago. A level is accepted
  // once the last DEB samples that have crossed the 2-stage delay all disagree
  // with the accepted level.
  logic [3:0] hist [6];
  logic [3:0] m_held, m_pend, m_mv;
  int         m_age [4];
  logic [3:0] nh, ev, gnt;
  int         nage [4];
  logic       flip;

  always_comb begin
    nh   = m_held;
    ev   = 4'b0000;
    gnt  = 4'b0000;
    flip = 1'b0;
    for (int b = 0; b < 4; b++) begin
      nage[b] = 0;
      flip = 1'b1;
      for (int k = 1; k <= DEB; k++)
        if (hist[k][b] == m_held[b]) flip = 1'b0;
      if (flip) nh[b] = ~m_held[b];
      if (nh[b] && !m_held[b]) begin
        ev[b] = 1'b1;
      end else if (nh[b] && m_held[b]) begin
        nage[b] = m_age[b] + 1;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
        if (nage[b] == RDLY || (nage[b] > RDLY && (nage[b] - RDLY) % RPER == 0))
          ev[b] = 1'b1;
`endif
      end
    end
    if (mv_tick) begin
      for (int b = 0; b < 4; b++)
        if (m_pend[b] && gnt == 4'b0000) gnt[b] = 1'b1;
    end
  end

  always @(posedge CLK or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 6; i++) hist[i] <= 4'b0000;
      for (int b = 0; b < 4; b++) m_age[b] <= 0;
      m_held <= 4'b0000;
      m_pend <= 4'b0000;
      m_mv   <= 4'b0000;
    end else begin
      hist[0] <= {Down, Up, Left, Right};
      for (int i = 1; i < 6; i++) hist[i] <= hist[i-1];
      for (int b = 0; b < 4; b++) m_age[b] <= nage[b];
      m_held <= nh;
      m_pend <= (m_pend & ~gnt) | ev;
      m_mv   <= gnt;
    end
  end

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) begin
    #1;
    if (chk_en) begin
      check4("cyc_held", held, m_held);
      check4("cyc_mv", mv, m_mv);
      check_int("cyc_mv_onehot", int'($countones(mv) <= 1), 1);
    end
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  int rcount;
  int rfirst;
  int rlast;

  initial begin
    clear = 1'b1;
    Left = 1'b0; Right = 1'b0; Up = 1'b0; Down = 1'b0; mv_tick = 1'b0;
    nclk(3);
    check4("reset_held", held, 4'b0000);
    check4("reset_mv", mv, 4'b0000);
    clear = 1'b0;
    chk_en = 1'b1;
    nclk(3);

    // Clean Right press, serviced by a single tick
    Right = 1'b1;
    nclk(5); check4("t1_held_c5", held, 4'b0000);
    nclk(1); check4("t1_held_c6", held, 4'b0001);
    check4("t1_model_held", m_held, 4'b0001);
    check4("t1_model_pend", m_pend, 4'b0001);
    nclk(4); mv_tick = 1'b1;
    nclk(1); check4("t1_mv_c11", mv, 4'b0001); mv_tick = 1'b0;
    nclk(1); check4("t1_mv_c12", mv, 4'b0000); Right = 1'b0;
    nclk(12);

    // Up glitch of 3 cycles must be ignored
    Up = 1'b1;
    nclk(3); Up = 1'b0;
    nclk(8); check4("t2_held", held, 4'b0000);
    check4("t2_model_pend", m_pend, 4'b0000);
    mv_tick = 1'b1;
    nclk(1); check4("t2_mv", mv, 4'b0000); mv_tick = 1'b0;
    nclk(4);

    // Left and Down pending, two ticks
    Left = 1'b1; Down = 1'b1;
    nclk(8); Left = 1'b0; Down = 1'b0;
    nclk(12); mv_tick = 1'b1;
    nclk(1); check4("t3_mv_c21", mv, 4'b0010); mv_tick = 1'b0;
    nclk(9); mv_tick = 1'b1;
    nclk(1); check4("t3_mv_c31", mv, 4'b1000); mv_tick = 1'b0;
    nclk(1); check4("t3_mv_c32", mv, 4'b0000);
    nclk(4);

    // Re-press lands on the same edge that consumes the old Right request
    Right = 1'b1;
    nclk(7); Right = 1'b0;
    nclk(7); Right = 1'b1;
    nclk(5); mv_tick = 1'b1;
    nclk(1); check4("t4_mv_c20", mv, 4'b0001);
    check4("t4_held_c20", held, 4'b0001);
    mv_tick = 1'b0;
    nclk(2); Right = 1'b0;
    nclk(3); mv_tick = 1'b1;
    nclk(1); check4("t4_mv_c26", mv, 4'b0001); mv_tick = 1'b0;
    nclk(1); check4("t4_mv_c27", mv, 4'b0000);
    nclk(8);

    // Async clear mid-debounce with Left already held
    Left = 1'b1;
    nclk(5); Down = 1'b1;
    nclk(5); check4("t5_held_pre", held, 4'b0010);
    clear = 1'b1;
    #1;
    check4("t5_held_clr", held, 4'b0000);
    check4("t5_mv_clr", mv, 4'b0000);
    nclk(2); clear = 1'b0;
    nclk(5); check4("t5_held_c17", held, 4'b0000);
    nclk(1); check4("t5_held_c18", held, 4'b1010);
    nclk(1); Left = 1'b0; Down = 1'b0;
    nclk(1); mv_tick = 1'b1;
    nclk(1); check4("t5_mv_c21", mv, 4'b0010);
    nclk(1); check4("t5_mv_c22", mv, 4'b1000);
    nclk(1); check4("t5_mv_c23", mv, 4'b0000); mv_tick = 1'b0;
    nclk(8);

    // Long Right hold with continuous ticks
    rcount = 0; rfirst = -1; rlast = -1;
    Right = 1'b1; mv_tick = 1'b1;
    for (int c = 1; c <= 55; c++) begin
      nclk(1);
      if (c == 43) Right = 1'b0;
      if (mv_right) begin
        rcount++;
        if (rfirst < 0) rfirst = c;
        rlast = c;
      end
    end
    mv_tick = 1'b0;
    check_int("t6_first", rfirst, 7);
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    check_int("t6_count", rcount, 4);
    check_int("t6_last", rlast, 43);
`else
    check_int("t6_count", rcount, 1);
    check_int("t6_last", rlast, 7);
`endif
    nclk(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 500000: consecutive stable cycles (about 10 ms at 50 MHz) needed to accept a level change.
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 25000000: cycles a button is held before its first auto-repeat.
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 7000000: cycles between later auto-repeats.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port clear, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have ports Left, Right, Up, Down, input, 1 bit each: raw asynchronous buttons, 1 = pressed.
REQ-007 The block SHALL have port mv_tick, input, 1 bit: one-cycle move strobe in the CLK domain from the move divider.
REQ-008 The block SHALL have ports mv_right, mv_left, mv_up, mv_down, output, 1 bit each: registered one-cycle move commands.
REQ-009 The block SHALL have port held, output, 4 bits, ordered {Down, Up, Left, Right}: debounced button levels.

Function
REQ-010 Each raw input SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-011 Debounce, per button: a counter SHALL increment while the synchronized value differs from the stable value.
REQ-012 The debounce counter SHALL clear when the synchronized value equals the stable value.
REQ-013 On the DEB_CYCLES-th consecutive differing cycle, the stable value SHALL toggle and the counter SHALL clear.
REQ-014 A clean raw edge SHALL appear on held exactly 2+DEB_CYCLES rising edges later.
REQ-015 A glitch shorter than DEB_CYCLES cycles SHALL leave held unchanged.
REQ-016 Counter width SHALL be ceil(log2(max(DEB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1)), with no wrap-around before terminal count.
REQ-017 A press event SHALL fire on a stable 0->1 transition only; 1->0 transitions produce no event.
REQ-018 Each direction SHALL have one sticky pending bit, set by that direction's press event.
REQ-019 A second event for a direction already pending SHALL be absorbed, not counted.
REQ-020 On a cycle with mv_tick=1, the arbiter SHALL select the highest-priority pending bit using priority Right > Left > Up > Down.
REQ-021 The arbiter SHALL use pending values as registered before that cycle's updates.
REQ-022 The selected pending bit SHALL clear, and the matching mv_* output SHALL be 1 on the next cycle only.
REQ-023 Non-selected pending bits SHALL persist to later ticks.
REQ-024 If an event sets a bit on the same cycle it is consumed, the set SHALL win: the bit stays pending and is served on a later tick.
REQ-025 mv_tick with no pending bits SHALL produce no output.
REQ-026 At most one mv_* output SHALL be 1 in any cycle.
REQ-027 If mv_tick is high for consecutive cycles, each cycle SHALL count as a separate tick.
REQ-028 The mv_* outputs SHALL be 0 in every cycle not following a serviced tick.

Reset
REQ-029 clear=1 SHALL asynchronously force to 0: synchronizer flops, stable values, all counters, pending bits, mv_* outputs and held.
REQ-030 A reset asserted mid-debounce or mid-repeat SHALL discard that progress.
REQ-031 A button held through reset release SHALL re-qualify after 2+DEB_CYCLES cycles and generate a fresh press event.
REQ-032 Deassertion of clear SHALL be used directly, with no internal reset synchronizer.

Configuration
REQ-033 With macro BUTTON_CONDITIONER_AUTOREPEAT_EN defined, a per-button repeat counter SHALL run while held=1.
REQ-034 With the macro defined, the counter SHALL reach REPEAT_DELAY after the press event, then every REPEAT_PERIOD cycles after that; each such point SHALL set the pending bit.
REQ-035 With the macro defined, held=0 or reset SHALL clear the repeat counter.
REQ-036 Without the macro, no repeat logic SHALL be built: only 0->1 transitions generate events, and the REPEAT_* parameters SHALL be accepted but unused.

Verification (bench parameters DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-037 Verify: Right raw 0->1 at cycle 0, held constant -> held[0]=1 at cycle 6; press event set; with mv_tick at cycle 10, mv_right=1 at cycle 11 only.
REQ-038 Verify: Up raw pulses high for 3 cycles -> held[2] stays 0; no pending bit; no mv_up on later ticks.
REQ-039 Verify: Left and Down both pending, ticks at cycles 20 and 30 -> mv_left at cycle 21, mv_down at cycle 31, no other outputs.
REQ-040 Verify: event sets Right pending on the same cycle as a tick that consumes Right -> Right still pending; next tick gives mv_right.
REQ-041 Verify: clear pulsed while Down is held with its debounce counter at 3 -> all outputs 0 at once; after release, held[3]=1 six cycles later and one fresh event.
REQ-042 Verify: with BUTTON_CONDITIONER_AUTOREPEAT_EN, Right held 40 cycles past qualification -> events at +0, +20, +28, +36; without the macro -> one event only.
